// File: rtl/hilo_pkg.sv
// Shared types and constants for the HI/LO writeback pipeline.
// Optional feature macro used by this slice: HILO_FWD_EN.
package hilo_pkg;

    localparam int unsigned HILO_DATA_W = 32;

    localparam logic SEL_HI = 1'b0;
    localparam logic SEL_LO = 1'b1;

    typedef struct packed {
        logic                   valid;
        logic                   hi_we;
        logic                   lo_we;
        logic [HILO_DATA_W-1:0] hi;
        logic [HILO_DATA_W-1:0] lo;
    } hilo_stage_t;

endpackage

// File: rtl/hilo_writeback_stage_latch.sv
// One HI/LO pipeline latch (used for MEM and WB): holds on stall, drops the entry on kill.
// Behaviour is the same with or without HILO_FWD_EN.
module hilo_stage_latch
    import hilo_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        kill,
    input  hilo_stage_t stage_in,
    output hilo_stage_t stage_out
);

    hilo_stage_t stage_d;
    hilo_stage_t stage_q;

    // A dead entry carries no enables, so downstream matching only needs to look at valid.
    always_comb begin
        stage_d = stage_q;
        if (!stall) begin
            stage_d = stage_in;
            if (kill || !stage_in.valid) begin
                stage_d.valid = 1'b0;
                stage_d.hi_we = 1'b0;
                stage_d.lo_we = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stage_q <= '0;
        end else begin
            stage_q <= stage_d;
        end
    end

    assign stage_out = stage_q;

endmodule

// File: rtl/hilo_writeback.sv
// HI/LO registers: EX -> MEM -> WB pipeline, architectural commit at WB, MFHI/MFLO read path.
// Define HILO_FWD_EN to forward in-flight writes; otherwise pending writes raise rd_hazard.
module hilo_writeback
    import hilo_pkg::*;
#(
    parameter int unsigned DATA_W = HILO_DATA_W
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              flush,
    input  logic              ex_valid,
    input  logic              ex_hi_we,
    input  logic              ex_lo_we,
    input  logic [DATA_W-1:0] ex_hi_in,
    input  logic [DATA_W-1:0] ex_lo_in,
    input  logic              rd_req,
    input  logic              rd_sel,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_hazard,
    output logic [DATA_W-1:0] hi_out,
    output logic [DATA_W-1:0] lo_out
);

    hilo_stage_t ex_stage;
    hilo_stage_t mem_stage;
    hilo_stage_t wb_stage;

    logic              ex_live;
    logic [DATA_W-1:0] hi_d, hi_q;
    logic [DATA_W-1:0] lo_d, lo_q;
    logic [DATA_W-1:0] arch_val;
    logic              ex_match, mem_match, wb_match;

    assign ex_live = ex_valid & ~flush & (ex_hi_we | ex_lo_we);

    // flush is applied as the MEM latch kill, so ex_stage.valid omits it.
    always_comb begin
        ex_stage       = '0;
        ex_stage.valid = ex_valid & (ex_hi_we | ex_lo_we);
        ex_stage.hi_we = ex_hi_we;
        ex_stage.lo_we = ex_lo_we;
        ex_stage.hi    = ex_hi_in;
        ex_stage.lo    = ex_lo_in;
    end

    hilo_stage_latch u_mem (
        .clk       (clk),
        .rst       (rst),
        .stall     (stall),
        .kill      (flush),
        .stage_in  (ex_stage),
        .stage_out (mem_stage)
    );

    hilo_stage_latch u_wb (
        .clk       (clk),
        .rst       (rst),
        .stall     (stall),
        .kill      (1'b0),
        .stage_in  (mem_stage),
        .stage_out (wb_stage)
    );

    always_comb begin
        hi_d = hi_q;
        lo_d = lo_q;
        if (!stall && wb_stage.valid) begin
            if (wb_stage.hi_we) hi_d = wb_stage.hi;
            if (wb_stage.lo_we) lo_d = wb_stage.lo;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hi_q <= '0;
            lo_q <= '0;
        end else begin
            hi_q <= hi_d;
            lo_q <= lo_d;
        end
    end

    assign hi_out = hi_q;
    assign lo_out = lo_q;

    always_comb begin
        arch_val  = (rd_sel == SEL_LO) ? lo_q : hi_q;
        ex_match  = ex_live & ((rd_sel == SEL_LO) ? ex_lo_we : ex_hi_we);
        mem_match = mem_stage.valid & ((rd_sel == SEL_LO) ? mem_stage.lo_we : mem_stage.hi_we);
        wb_match  = wb_stage.valid & ((rd_sel == SEL_LO) ? wb_stage.lo_we : wb_stage.hi_we);
    end

`ifdef HILO_FWD_EN
    // Youngest in-flight write wins: EX, then MEM, then WB.
    always_comb begin
        rd_data = arch_val;
        if (rd_req) begin
            if (ex_match) begin
                rd_data = (rd_sel == SEL_LO) ? ex_lo_in : ex_hi_in;
            end else if (mem_match) begin
                rd_data = (rd_sel == SEL_LO) ? mem_stage.lo : mem_stage.hi;
            end else if (wb_match) begin
                rd_data = (rd_sel == SEL_LO) ? wb_stage.lo : wb_stage.hi;
            end
        end
    end

    assign rd_hazard = 1'b0;
`else
    assign rd_data   = arch_val;
    assign rd_hazard = rd_req & (ex_match | mem_match | wb_match);
`endif

endmodule
